// File: rtl/fcp_slave_ctrl.sv
// FCP slave logical layer: command decode, register map, PING/RESPOND requests
// and a stepped voltage-index ramp over an N-entry discrete voltage table.
module fcp_slave_ctrl #(
  parameter int unsigned         N_VOUT       = 3,
  parameter int unsigned         VIDX_W       = 2,
  parameter logic [N_VOUT*8-1:0] VOUT_TABLE   = {8'd120, 8'd90, 8'd50},
  parameter int unsigned         STEP_CYCLES  = 100,
  parameter int unsigned         AFC_RESP_CNT = 3,
  parameter int unsigned         AFC_VIDX     = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N_VOUT-1:0] vout_en_mask,
  input  logic              ping_from_master,
  input  logic              reset_from_master,
  input  logic              afc_iden,
  input  logic              crc_error,
  input  logic              par_error,
  input  logic [23:0]       rx_data,
  input  logic              rx_data_valid,
  input  logic              tx_done,
  output logic              pl_tx_en,
  output logic              pl_tx_type,
  output logic              pl_tx_afc,
  output logic [15:0]       pl_tx_data,
  output logic [VIDX_W-1:0] out_vidx,
  output logic              ramp_busy
);

  localparam int unsigned CNT_W  = $clog2(AFC_RESP_CNT + 1);
  localparam int unsigned STEP_W = $clog2(STEP_CYCLES);
  localparam logic [7:0]  ACK    = 8'h08;
  localparam logic [7:0]  NACK   = 8'h03;

  typedef enum logic [1:0] {IDLE, SEND_PING, SEND_RESPOND} state_t;

  state_t              state, next;
  logic [N_VOUT-1:0]   en;
  logic                pending, afc_pr, commit;
  logic [CNT_W-1:0]    afc_cnt;
  logic                afc_done, afc_hit, afc_ok;
  logic [VIDX_W-1:0]   target, target_d, cfg_idx;
  logic                cfg_hit;
  logic [STEP_W-1:0]   step_cnt;
  logic [7:0]          vout_cfg, cur_vout, en_cnt;
  logic                oc_pulse;
  logic [1:0]          sstat;

  logic                s1_valid, s1_wr, s1_rd;
  logic [7:0]          s1_addr, s1_data;
  logic                rd_hit, wr_hit;
  logic [7:0]          rd_val;
  logic                s2_valid, s2_rd;
  logic [7:0]          resp, s2_rdata;
  logic                cmd_live, cmd_wr, cmd_sstat_rd;
  logic [7:0]          cmd_addr, cmd_data;

  assign en        = vout_en_mask | N_VOUT'(1);
  assign ramp_busy = (out_vidx != target);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:         if (ping_from_master) next = SEND_PING;
      SEND_PING:    if (tx_done) next = pending ? SEND_RESPOND : IDLE;
      SEND_RESPOND: if (tx_done) next = IDLE;
      default:      next = IDLE;
    endcase
    if (reset_from_master) next = IDLE;
  end

  assign commit     = (state == SEND_PING) && (next == SEND_RESPOND);
  assign pl_tx_en   = ((state == IDLE) && (next == SEND_PING)) || commit;
  assign pl_tx_type = (next == SEND_RESPOND);
  assign pl_tx_afc  = pl_tx_type & afc_pr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending <= 1'b0;
      afc_pr  <= 1'b0;
    end else begin
      if (reset_from_master)               pending <= 1'b0;
      else if (rx_data_valid || afc_iden)  pending <= 1'b1;
      else if (commit)                     pending <= 1'b0;
      if (afc_iden)                               afc_pr <= 1'b1;
      else if (state != IDLE && next == IDLE)     afc_pr <= 1'b0;
    end
  end

  // ---------------- decode / register map ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_wr    <= 1'b0;
      s1_rd    <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rx_data_valid;
      if (rx_data_valid) begin
        s1_wr   <= (rx_data[23:16] == 8'h0B);
        s1_rd   <= (rx_data[23:16] == 8'h00) && (rx_data[15:8] == 8'h0C);
        s1_addr <= (rx_data[23:16] == 8'h0B) ? rx_data[15:8] : rx_data[7:0];
        s1_data <= rx_data[7:0];
      end
    end
  end

  always_comb begin
    en_cnt   = '0;
    cur_vout = '0;
    for (int unsigned k = 0; k < N_VOUT; k++) begin
      en_cnt = en_cnt + {7'b0, en[k]};
      if (out_vidx == VIDX_W'(k)) cur_vout = VOUT_TABLE[8*k +: 8];
    end
  end

  always_comb begin
    rd_hit = 1'b1;
    rd_val = '0;
    case (s1_addr)
      8'h00: rd_val = 8'h01;
      8'h01: rd_val = 8'h20;
      8'h02: rd_val = 8'h00;
      8'h03: rd_val = {6'b0, sstat};
      8'h04: rd_val = 8'hBB;
      8'h20: rd_val = 8'h01;
      8'h21: rd_val = en_cnt - 8'd1;
      8'h22: rd_val = 8'h24;
      8'h28: rd_val = {7'b0, ramp_busy};
      8'h29: rd_val = cur_vout;
      8'h2B: rd_val = {7'b0, oc_pulse};
      8'h2C: rd_val = vout_cfg;
      default: begin
        rd_hit = 1'b0;
        for (int unsigned k = 0; k < N_VOUT; k++) begin
          if (s1_addr == 8'(8'h30 + k) && en[k]) begin
            rd_hit = 1'b1;
            rd_val = VOUT_TABLE[8*k +: 8];
          end
        end
      end
    endcase
  end

  assign wr_hit = (s1_addr == 8'h02) || (s1_addr == 8'h2B) || (s1_addr == 8'h2C);

  // The decoded command is held until it commits on entry to SEND_RESPOND, so a
  // later AFC-only respond cannot replay an already committed write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid     <= 1'b0;
      s2_rd        <= 1'b0;
      resp         <= '0;
      s2_rdata     <= '0;
      cmd_live     <= 1'b0;
      cmd_wr       <= 1'b0;
      cmd_sstat_rd <= 1'b0;
      cmd_addr     <= '0;
      cmd_data     <= '0;
      pl_tx_data   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_rd        <= s1_rd;
        resp         <= ((s1_rd && rd_hit) || (s1_wr && wr_hit)) ? ACK : NACK;
        s2_rdata     <= (s1_rd && rd_hit) ? rd_val : 8'h00;
        cmd_live     <= 1'b1;
        cmd_wr       <= s1_wr && wr_hit;
        cmd_sstat_rd <= s1_rd && (s1_addr == 8'h03);
        cmd_addr     <= s1_addr;
        cmd_data     <= s1_data;
      end else if (commit || reset_from_master) begin
        cmd_live <= 1'b0;
      end
      if (s2_valid) pl_tx_data <= s2_rd ? {resp, s2_rdata} : {8'h00, resp};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      oc_pulse <= 1'b0;
      vout_cfg <= VOUT_TABLE[7:0];
      sstat    <= '0;
    end else begin
      oc_pulse <= commit && cmd_live && cmd_wr && (cmd_addr == 8'h2B) && cmd_data[0];
      if (commit && cmd_live && cmd_wr && (cmd_addr == 8'h2C)) vout_cfg <= cmd_data;
      sstat <= ((commit && cmd_live && cmd_sstat_rd) ? 2'b00 : sstat) | {crc_error, par_error};
    end
  end

  // ---------------- target selection / AFC ----------------
  always_comb begin
    cfg_hit = 1'b0;
    cfg_idx = '0;
    afc_ok  = 1'b0;
    for (int unsigned k = N_VOUT; k > 0; k--) begin
      if (en[k-1] && (VOUT_TABLE[8*(k-1) +: 8] == vout_cfg)) begin
        cfg_hit = 1'b1;
        cfg_idx = VIDX_W'(k - 1);
      end
    end
    for (int unsigned k = 0; k < N_VOUT; k++) begin
      if (k == AFC_VIDX && en[k]) afc_ok = 1'b1;
    end
  end

  assign afc_done = tx_done && afc_pr && !pending;
  assign afc_hit  = afc_done && !rx_data_valid && (afc_cnt == CNT_W'(AFC_RESP_CNT - 1));

  always_comb begin
    target_d = target;
    if (reset_from_master)       target_d = '0;
    else if (afc_hit && afc_ok)  target_d = VIDX_W'(AFC_VIDX);
    else if (oc_pulse && cfg_hit) target_d = cfg_idx;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      afc_cnt <= '0;
    end else if (rx_data_valid) begin
      afc_cnt <= '0;
    end else if (afc_done && (afc_cnt != CNT_W'(AFC_RESP_CNT))) begin
      afc_cnt <= afc_cnt + CNT_W'(1);
    end
  end

  // ---------------- ramp ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      target   <= '0;
      out_vidx <= '0;
      step_cnt <= '0;
    end else begin
      target <= target_d;
      if (target_d != target) begin
        step_cnt <= '0;
      end else if (ramp_busy) begin
        if (step_cnt == STEP_W'(STEP_CYCLES - 1)) begin
          step_cnt <= '0;
          out_vidx <= (target > out_vidx) ? out_vidx + VIDX_W'(1) : out_vidx - VIDX_W'(1);
        end else begin
          step_cnt <= step_cnt + STEP_W'(1);
        end
      end else begin
        step_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fcp_slave_ctrl.sv
// Directed + randomized bench for fcp_slave_ctrl with a behavioural register-map model.
module tb_fcp_slave_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  vout_en_mask;
  logic        ping_from_master, reset_from_master, afc_iden, crc_error, par_error;
  logic [23:0] rx_data;
  logic        rx_data_valid, tx_done;
  logic        pl_tx_en, pl_tx_type, pl_tx_afc;
  logic [15:0] pl_tx_data;
  logic [1:0]  out_vidx;
  logic        ramp_busy;

  always #5 clk = ~clk;

  fcp_slave_ctrl #(
    .N_VOUT(3), .VIDX_W(2), .VOUT_TABLE({8'd120, 8'd90, 8'd50}),
    .STEP_CYCLES(100), .AFC_RESP_CNT(3), .AFC_VIDX(1)
  ) dut (
    .clk(clk), .rstn(rstn), .vout_en_mask(vout_en_mask),
    .ping_from_master(ping_from_master), .reset_from_master(reset_from_master),
    .afc_iden(afc_iden), .crc_error(crc_error), .par_error(par_error),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .tx_done(tx_done),
    .pl_tx_en(pl_tx_en), .pl_tx_type(pl_tx_type), .pl_tx_afc(pl_tx_afc),
    .pl_tx_data(pl_tx_data), .out_vidx(out_vidx), .ramp_busy(ramp_busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state: voltage table, current index, busy, VOUT_CONFIG, SSTAT.
  logic [7:0] tbl [4] = '{8'd50, 8'd90, 8'd120, 8'd0};
  logic [1:0] m_vidx  = 2'd0;
  logic       m_busy  = 1'b0;
  logic [7:0] m_vcfg  = 8'd50;
  logic [7:0] m_sstat = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      $error("%s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_resp(input logic [23:0] cmd, input logic [2:0] mask);
    logic [2:0] m;
    logic [7:0] a, v;
    logic       ok;
    m = mask | 3'b001;
    if (cmd[23:16] == 8'h0B)
      return {8'h00, (cmd[15:8] == 8'h02 || cmd[15:8] == 8'h2B || cmd[15:8] == 8'h2C) ? 8'h08 : 8'h03};
    if (cmd[23:8] != 16'h000C) return 16'h0003;
    a  = cmd[7:0];
    ok = 1'b1;
    v  = 8'h00;
    case (a)
      8'h00: v = 8'h01;
      8'h01: v = 8'h20;
      8'h02: v = 8'h00;
      8'h03: v = m_sstat;
      8'h04: v = 8'hBB;
      8'h20: v = 8'h01;
      8'h21: v = 8'($countones(m)) - 8'd1;
      8'h22: v = 8'h24;
      8'h28: v = {7'b0, m_busy};
      8'h29: v = tbl[m_vidx];
      8'h2B: v = 8'h00;
      8'h2C: v = m_vcfg;
      8'h30: v = tbl[0];
      8'h31: begin ok = m[1]; v = m[1] ? tbl[1] : 8'h00; end
      8'h32: begin ok = m[2]; v = m[2] ? tbl[2] : 8'h00; end
      default: ok = 1'b0;
    endcase
    return ok ? {8'h08, v} : 16'h0300;
  endfunction

  // rx strobe, pipeline settle, PING request, RESPOND request (commit), respond done: 7 edges.
  task automatic transact(input logic [23:0] cmd, input logic [1:0] err_commit, output logic [15:0] txd);
    rx_data = cmd; rx_data_valid = 1'b1;
    @(posedge clk); #1; rx_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; ping_from_master = 1'b1;
    #1; check("ping_en", pl_tx_en, 1); check("ping_type", pl_tx_type, 0);
    @(posedge clk); #1; ping_from_master = 1'b0; tx_done = 1'b1; {crc_error, par_error} = err_commit;
    #1; check("resp_en", pl_tx_en, 1); check("resp_type", pl_tx_type, 1); check("resp_afc", pl_tx_afc, 0);
    txd = pl_tx_data;
    @(posedge clk); #1; {crc_error, par_error} = 2'b00;
    #1; check("done_en", pl_tx_en, 0);
    @(posedge clk); #1; tx_done = 1'b0;
  endtask

  task automatic do_cmd(input string tag, input logic [23:0] cmd, input logic [15:0] exp);
    logic [15:0] txd;
    transact(cmd, 2'b00, txd);
    check(tag, txd, exp);
  endtask

  task automatic afc_flow();
    @(posedge clk); #1; afc_iden = 1'b1;
    @(posedge clk); #1; afc_iden = 1'b0; ping_from_master = 1'b1;
    #1; check("afc_ping_en", pl_tx_en, 1);
    @(posedge clk); #1; ping_from_master = 1'b0; tx_done = 1'b1;
    #1; check("afc_resp_en", pl_tx_en, 1); check("afc_resp_type", pl_tx_type, 1); check("afc_flag", pl_tx_afc, 1);
    @(posedge clk); #1;
    #1; check("afc_done_en", pl_tx_en, 0);
    @(posedge clk); #1; tx_done = 1'b0;
  endtask

  task automatic wait_vidx(input logic [1:0] exp, input int budget, output int n);
    n = 0;
    while (out_vidx !== exp && n < budget) begin
      @(posedge clk); #1; n++;
    end
  endtask

  initial begin
    logic [7:0]  addrs [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h20, 8'h21, 8'h22,
                                8'h28, 8'h29, 8'h2B, 8'h2C, 8'h30, 8'h31, 8'h32, 8'h33};
    logic [23:0] cmd;
    logic [15:0] txd;
    logic [7:0]  a;
    int          n, t0, tr;

    rstn = 1'b0; vout_en_mask = 3'b011;
    ping_from_master = 0; reset_from_master = 0; afc_iden = 0; crc_error = 0; par_error = 0;
    rx_data = '0; rx_data_valid = 0; tx_done = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_en", pl_tx_en, 0);   check("rst_tx_type", pl_tx_type, 0);
    check("rst_tx_afc", pl_tx_afc, 0); check("rst_tx_data", pl_tx_data, 0);
    check("rst_vidx", out_vidx, 0);    check("rst_busy", ramp_busy, 0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    do_cmd("rd21_mask011", 24'h000C21, 16'h0801);
    do_cmd("rd32_disabled", 24'h000C32, 16'h0300);

    for (int i = 0; i < 24; i++) begin
      vout_en_mask = 3'($urandom);
      case ($urandom_range(0, 3))
        0: cmd = {16'h000C, addrs[$urandom_range(0, 15)]};
        1: cmd = {16'h000C, 8'($urandom)};
        2: begin
          a = 8'($urandom);
          if (a == 8'h2B || a == 8'h2C) a = 8'h02;
          cmd = {8'h0B, a, 8'($urandom)};
        end
        default: begin
          cmd = 24'($urandom);
          if (cmd[23:16] == 8'h0B) cmd[23:16] = 8'h0A;
        end
      endcase
      transact(cmd, 2'b00, txd);
      check($sformatf("rand%0d_cmd%06h", i, cmd), txd, model_resp(cmd, vout_en_mask));
    end

    // VOUT_CONFIG 90 with entry 1 disabled: no match, target unchanged.
    vout_en_mask = 3'b101;
    do_cmd("wr2C_90", 24'h0B2C5A, 16'h0008);
    do_cmd("unknown_cmd", 24'h123456, 16'h0003);
    do_cmd("wr2B_nomatch", 24'h0B2B01, 16'h0008);
    check("nomatch_busy", ramp_busy, 0);
    repeat (110) @(posedge clk);
    #1; check("nomatch_vidx", out_vidx, 0);

    vout_en_mask = 3'b111;
    do_cmd("wr2B_match", 24'h0B2B01, 16'h0008);
    check("ramp_busy_hi", ramp_busy, 1);
    wait_vidx(2'd1, 300, n);
    check("step_latency", n, 100);
    check("ramp_busy_lo", ramp_busy, 0);
    do_cmd("rd29_90", 24'h000C29, 16'h085A);
    do_cmd("rd2C_90", 24'h000C2C, 16'h085A);
    do_cmd("rd28_idle", 24'h000C28, 16'h0800);

    do_cmd("wr2C_50", 24'h0B2C32, 16'h0008);
    do_cmd("wr2B_to0", 24'h0B2B01, 16'h0008);
    wait_vidx(2'd0, 300, n);
    check("down_latency", n, 100);

    // 120 from index 0, retarget to 50 at cycle 150.
    do_cmd("wr2C_120", 24'h0B2C78, 16'h0008);
    do_cmd("wr2B_to2", 24'h0B2B01, 16'h0008);
    t0 = cyc;
    do_cmd("wr2C_50b", 24'h0B2C32, 16'h0008);
    while (cyc < t0 + 143) begin @(posedge clk); #1; end
    do_cmd("wr2B_retgt", 24'h0B2B01, 16'h0008);
    check("retgt_vidx", out_vidx, 1);
    wait_vidx(2'd0, 300, n);
    check("retgt_return_cyc", cyc - t0, 250);
    check("retgt_busy", ramp_busy, 0);

    @(posedge clk); #1; crc_error = 1'b1; par_error = 1'b1;
    @(posedge clk); #1; crc_error = 1'b0; par_error = 1'b0;
    do_cmd("sstat_both", 24'h000C03, 16'h0803);
    do_cmd("sstat_clr", 24'h000C03, 16'h0800);
    @(posedge clk); #1; crc_error = 1'b1;
    @(posedge clk); #1; crc_error = 1'b0;
    transact(24'h000C03, 2'b01, txd);
    check("sstat_crc", txd, 16'h0802);
    do_cmd("sstat_setwins", 24'h000C03, 16'h0801);
    do_cmd("sstat_clr2", 24'h000C03, 16'h0800);

    afc_flow();
    afc_flow();
    do_cmd("rd00_afcclr", 24'h000C00, 16'h0801);
    afc_flow();
    afc_flow();
    repeat (120) @(posedge clk);
    #1; check("afc_nochange_vidx", out_vidx, 0); check("afc_nochange_busy", ramp_busy, 0);
    afc_flow();
    check("afc_busy", ramp_busy, 1);
    wait_vidx(2'd1, 300, n);
    check("afc_step", n, 100);

    do_cmd("wr2C_120b", 24'h0B2C78, 16'h0008);
    do_cmd("wr2B_to2b", 24'h0B2B01, 16'h0008);
    repeat (30) @(posedge clk);
    #1; rx_data = 24'h000C00; rx_data_valid = 1'b1;
    @(posedge clk); #1; rx_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; ping_from_master = 1'b1;
    #1; check("mr_ping_en", pl_tx_en, 1);
    @(posedge clk); #1; ping_from_master = 1'b0; reset_from_master = 1'b1;
    @(posedge clk); #1; reset_from_master = 1'b0; tr = cyc; tx_done = 1'b1;
    #1; check("mr_idle_txdone", pl_tx_en, 0);
    @(posedge clk); #1; tx_done = 1'b0; ping_from_master = 1'b1;
    #1; check("mr_ping_en2", pl_tx_en, 1); check("mr_ping_type2", pl_tx_type, 0);
    @(posedge clk); #1; ping_from_master = 1'b0; tx_done = 1'b1;
    #1; check("mr_pending_clr", pl_tx_en, 0);
    @(posedge clk); #1; tx_done = 1'b0;
    wait_vidx(2'd0, 300, n);
    check("mr_down_cyc", cyc - tr, 100);
    check("mr_busy", ramp_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
